// File: rtl/mmcm_drp_reconfig.sv
// MMCME2_ADV runtime reconfiguration sequencer.
// Holds the MMCM in reset, read-modify-writes every DRP register listed in an
// external synchronous ROM, then releases reset and waits for LOCKED.
module mmcm_drp_reconfig #(
   parameter int TABLE_DEPTH  = 23,    // entries per reconfiguration (1..32)
   parameter int TBL_AW       = 5,     // ROM address width
   parameter int RST_SETTLE   = 8,     // cycles of reset before the first DRP access
   parameter int DRDY_TIMEOUT = 255,   // DEN-to-DRDY limit, must be >= 2
   parameter int LOCK_TIMEOUT = 65535  // release-to-lock limit, must be >= 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [TBL_AW-1:0] tbl_addr,
   input  logic [38:0]       tbl_data,
   output logic [6:0]        drp_addr,
   output logic [15:0]       drp_di,
   input  logic [15:0]       drp_do,
   output logic              drp_den,
   output logic              drp_dwe,
   input  logic              drp_drdy,
   output logic              mmcm_rst,
   input  logic              mmcm_locked
);

   // One shared counter serves the settle, DRDY and lock waits; size it for the largest.
   localparam int CNT_MAX0 = (RST_SETTLE > DRDY_TIMEOUT) ? RST_SETTLE : DRDY_TIMEOUT;
   localparam int CNT_MAX  = (CNT_MAX0 > LOCK_TIMEOUT) ? CNT_MAX0 : LOCK_TIMEOUT;
   localparam int CW       = $clog2(CNT_MAX + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RST_WAIT,
      S_FETCH,      // ROM address presented, data arrives next cycle
      S_LOAD,       // ROM data captured
      S_RD,
      S_RD_WAIT,
      S_WR,
      S_WR_WAIT,
      S_RELEASE,
      S_LOCK_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [TBL_AW-1:0] idx_q, idx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     cnt_inc;
   logic [6:0]        addr_q, addr_d;
   logic [15:0]       mask_q, mask_d;
   logic [15:0]       data_q, data_d;
   logic [15:0]       di_q, di_d;
   logic              error_q, error_d;
   logic              lock_meta_q;
   logic              lock_s_q;

   // Saturating increment: a timeout counter never wraps back to a small value.
   assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

   // Moore outputs decoded from the state register.
   assign busy     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
   assign done     = (state_q == S_DONE);
   assign error    = error_q;
   assign mmcm_rst = (state_q == S_RST_WAIT) || (state_q == S_FETCH) || (state_q == S_LOAD) ||
                     (state_q == S_RD) || (state_q == S_RD_WAIT) ||
                     (state_q == S_WR) || (state_q == S_WR_WAIT);
   assign drp_den  = (state_q == S_RD) || (state_q == S_WR);
   assign drp_dwe  = (state_q == S_WR);
   assign drp_addr = addr_q;
   assign drp_di   = di_q;
   assign tbl_addr = idx_q;

   // Two-flop synchronizer for the asynchronous LOCKED input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         lock_meta_q <= mmcm_locked;
         lock_s_q    <= lock_meta_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         mask_q  <= '0;
         data_q  <= '0;
         di_q    <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         mask_q  <= mask_d;
         data_q  <= data_d;
         di_q    <= di_d;
         error_q <= error_d;
      end
   end

   // Next-state logic; each wait state clears the counter on entry and times out
   // so that the error flag rises exactly TIMEOUT cycles after the triggering edge.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      mask_d  = mask_q;
      data_d  = data_q;
      di_d    = di_q;
      error_d = error_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RST_WAIT;
               idx_d   = '0;
               cnt_d   = '0;
               error_d = 1'b0;
            end
         end
         S_RST_WAIT: begin
            if (cnt_q == CW'(RST_SETTLE - 1)) begin
               state_d = S_FETCH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_FETCH: state_d = S_LOAD;
         S_LOAD: begin
            addr_d  = tbl_data[38:32];
            mask_d  = tbl_data[31:16];
            data_d  = tbl_data[15:0];
            state_d = S_RD;
         end
         S_RD: begin
            cnt_d   = '0;
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (drp_drdy) begin
               // Mask bits keep the live register value, the rest take the table bits.
               di_d    = (drp_do & mask_q) | (data_q & ~mask_q);
               state_d = S_WR;
            end else if (cnt_q == CW'(DRDY_TIMEOUT - 2)) begin
               state_d = S_ERR;
               error_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_WR: begin
            cnt_d   = '0;
            state_d = S_WR_WAIT;
         end
         S_WR_WAIT: begin
            if (drp_drdy) begin
               if (idx_q == TBL_AW'(TABLE_DEPTH - 1)) begin
                  state_d = S_RELEASE;
               end else begin
                  idx_d   = idx_q + TBL_AW'(1);
                  state_d = S_FETCH;
               end
            end else if (cnt_q == CW'(DRDY_TIMEOUT - 2)) begin
               state_d = S_ERR;
               error_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_RELEASE: begin
            cnt_d   = '0;
            state_d = S_LOCK_WAIT;
         end
         S_LOCK_WAIT: begin
            if (lock_s_q) begin
               state_d = S_DONE;
            end else if (cnt_q == CW'(LOCK_TIMEOUT - 2)) begin
               state_d = S_ERR;
               error_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Self-checking bench for mmcm_drp_reconfig: ROM model, DRP slave model with
// programmable DRDY latency, MMCM lock model, and a write scoreboard.
module tb_mmcm_drp_reconfig;

   localparam int DEPTH  = 2;
   localparam int AW     = 5;
   localparam int SETTLE = 8;
   localparam int DTO    = 255;
   localparam int LTO    = 1000;

   logic          clk;
   logic          rst;
   logic          start;
   logic          busy, done, error;
   logic [AW-1:0] tbl_addr;
   logic [38:0]   tbl_data;
   logic [6:0]    drp_addr;
   logic [15:0]   drp_di;
   logic [15:0]   drp_do;
   logic          drp_den, drp_dwe;
   logic          drp_drdy;
   logic          mmcm_rst;
   logic          mmcm_locked;

   mmcm_drp_reconfig #(
      .TABLE_DEPTH (DEPTH),
      .TBL_AW      (AW),
      .RST_SETTLE  (SETTLE),
      .DRDY_TIMEOUT(DTO),
      .LOCK_TIMEOUT(LTO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .tbl_addr   (tbl_addr),
      .tbl_data   (tbl_data),
      .drp_addr   (drp_addr),
      .drp_di     (drp_di),
      .drp_do     (drp_do),
      .drp_den    (drp_den),
      .drp_dwe    (drp_dwe),
      .drp_drdy   (drp_drdy),
      .mmcm_rst   (mmcm_rst),
      .mmcm_locked(mmcm_locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Synchronous table ROM
   logic [38:0] rom [0:31];
   always @(posedge clk) tbl_data <= rom[tbl_addr];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [22:0] exp_q [$];   // {drp addr, written value}

   task automatic push_exp(input logic [6:0] a, input logic [15:0] v);
      exp_q.push_back({a, v});
   endtask

   function automatic logic [38:0] mk(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
      return {a, m, d};
   endfunction

   // Model knobs and per-operation statistics
   int          lat        = 3;
   bit          hang       = 1'b0;
   logic [15:0] do_val     = 16'hFFFF;
   int          lock_delay = -1;
   int          pend       = 0;
   bit          pend_wr    = 1'b0;
   int n_rd, n_wr, n_done;
   int rd0_cyc, rel_cyc, err_cyc, done_cyc, rise_cyc, wr_edge;
   logic [6:0] rd0_addr;
   logic prev_rst = 1'b0;
   logic prev_err = 1'b0;

   task automatic clear_stats();
      n_rd = 0; n_wr = 0; n_done = 0;
      rd0_cyc = -1; rel_cyc = -1; err_cyc = -1; done_cyc = -1; rise_cyc = -1; wr_edge = -1;
      rd0_addr = '0;
   endtask

   // DRP slave, MMCM lock model and monitor, all evaluated on the falling edge.
   initial begin
      drp_drdy    = 1'b0;
      drp_do      = 16'h0000;
      mmcm_locked = 1'b0;
      clear_stats();
      forever begin
         @(negedge clk);
         drp_drdy = 1'b0;
         if (rst) begin
            pend = 0;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               drp_drdy = 1'b1;
               drp_do   = do_val;
               if (pend_wr) wr_edge = cyc + 1;
            end
         end
         if (!rst && drp_den) begin
            check_eq("den_while_outstanding", pend, 0);
            if (drp_dwe) begin
               n_wr++;
               $display("[%0d] drp write addr=0x%02h data=0x%04h", cyc, drp_addr, drp_di);
               check_eq("sb_has_entry", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  logic [22:0] e;
                  e = exp_q.pop_front();
                  check_eq("wr_addr", drp_addr, e[22:16]);
                  check_eq("wr_data", drp_di, e[15:0]);
               end
            end else begin
               n_rd++;
               $display("[%0d] drp read  addr=0x%02h", cyc, drp_addr);
               if (rd0_cyc < 0) begin
                  rd0_cyc  = cyc;
                  rd0_addr = drp_addr;
               end
            end
            if (!(hang && !drp_dwe)) begin
               pend    = lat - 1;
               pend_wr = drp_dwe;
            end
         end
         if (!prev_rst && mmcm_rst) rise_cyc = cyc;
         if (prev_rst && !mmcm_rst) rel_cyc = cyc;
         if (mmcm_rst)
            mmcm_locked = 1'b0;
         else if (lock_delay >= 0 && rel_cyc >= 0 && cyc == rel_cyc + lock_delay - 1)
            mmcm_locked = 1'b1;
         if (error && !prev_err) err_cyc = cyc;
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
         prev_rst = mmcm_rst;
         prev_err = error;
      end
   end

   task automatic pulse_start(output int s_edge);
      @(negedge clk);
      start  = 1'b1;
      s_edge = cyc + 1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic pulse_at(input int edge_no);
      while (cyc < edge_no - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (n_done > 0 || err_cyc >= 0) break;
      end
      check_eq({tag, "_finished"}, (n_done > 0 || err_cyc >= 0), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic push_nominal();
      push_exp(7'h08, 16'h1145);
      push_exp(7'h09, 16'hFC80);
   endtask

   initial begin
      int s;
      for (int i = 0; i < 32; i++) rom[i] = '0;
      start = 1'b0;
      rst   = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_error", error, 0);
      check_eq("rst_tbl_addr", tbl_addr, 0);
      check_eq("rst_drp_addr", drp_addr, 0);
      check_eq("rst_drp_di", drp_di, 0);
      check_eq("rst_den", drp_den, 0);
      check_eq("rst_dwe", drp_dwe, 0);
      check_eq("rst_mmcm_rst", mmcm_rst, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Nominal two-entry reconfiguration
      rom[0] = mk(7'h08, 16'h1000, 16'h0145);
      rom[1] = mk(7'h09, 16'hFC00, 16'h0080);
      do_val = 16'hFFFF; lat = 3; lock_delay = 100; hang = 1'b0;
      push_nominal();
      clear_stats();
      pulse_start(s);
      wait_end("nom", 600);
      check_eq("nom_rst_rise", rise_cyc, s);
      check_eq("nom_rst_fall_at_last_wr", rel_cyc, wr_edge);
      check_eq("nom_done_cycle", done_cyc, rel_cyc + 100 + 2);
      check_eq("nom_done_pulses", n_done, 1);
      check_eq("nom_reads", n_rd, 2);
      check_eq("nom_writes", n_wr, 2);
      check_eq("nom_error", error, 0);
      check_eq("nom_busy_after", busy, 0);
      check_eq("nom_sb_empty", exp_q.size(), 0);

      // DRDY never returned on the first read
      hang = 1'b1; lock_delay = -1;
      clear_stats();
      pulse_start(s);
      wait_end("drdy_to", 600);
      check_eq("drdy_to_latency", err_cyc - rd0_cyc, DTO);
      check_eq("drdy_to_error", error, 1);
      check_eq("drdy_to_busy", busy, 0);
      check_eq("drdy_to_mmcm_rst", mmcm_rst, 0);
      check_eq("drdy_to_writes", n_wr, 0);
      hang = 1'b0;

      // LOCKED never rises
      push_nominal();
      clear_stats();
      pulse_start(s);
      wait_end("lock_to", 1500);
      check_eq("lock_to_latency", err_cyc - rel_cyc, LTO);
      check_eq("lock_to_no_done", n_done, 0);
      check_eq("lock_to_error", error, 1);
      check_eq("lock_to_writes", n_wr, 2);

      // Start clears error; extra starts during the operation are ignored
      lock_delay = 40;
      push_nominal();
      clear_stats();
      pulse_start(s);
      check_eq("restart_error_cleared", error, 0);
      check_eq("restart_busy", busy, 1);
      pulse_at(s + 3);
      pulse_at(s + 20);
      pulse_at(s + 50);
      wait_end("ign", 600);
      repeat (20) @(negedge clk);
      check_eq("ign_reads", n_rd, 2);
      check_eq("ign_writes", n_wr, 2);
      check_eq("ign_done_pulses", n_done, 1);
      check_eq("ign_busy_after", busy, 0);
      check_eq("ign_sb_empty", exp_q.size(), 0);

      // Asynchronous reset during WR_WAIT of entry 1
      lock_delay = 20;
      push_nominal();
      clear_stats();
      pulse_start(s);
      for (int i = 0; i < 200 && n_wr < 2; i++) @(negedge clk);
      check_eq("rmo_reached_wr1", n_wr, 2);
      @(posedge clk);
      #2;
      check_eq("rmo_pre_mmcm_rst", mmcm_rst, 1);
      rst = 1'b1;
      #1;
      check_eq("rmo_mmcm_rst", mmcm_rst, 0);
      check_eq("rmo_den", drp_den, 0);
      check_eq("rmo_busy", busy, 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      push_nominal();
      clear_stats();
      pulse_start(s);
      wait_end("rmo_again", 600);
      check_eq("rmo_first_addr", rd0_addr, 7'h08);
      check_eq("rmo_done_pulses", n_done, 1);
      check_eq("rmo_writes", n_wr, 2);
      check_eq("rmo_sb_empty", exp_q.size(), 0);

      // Masking corners
      rom[0] = mk(7'h08, 16'hFFFF, 16'h1234);
      rom[1] = mk(7'h09, 16'h0000, 16'h1234);
      do_val = 16'hABCD; lock_delay = 10;
      push_exp(7'h08, 16'hABCD);
      push_exp(7'h09, 16'h1234);
      clear_stats();
      pulse_start(s);
      wait_end("mask", 600);
      check_eq("mask_done_pulses", n_done, 1);
      check_eq("mask_sb_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached (compared %0d, mismatched %0d)", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mmcm_drp_reconfig.md
Name: mmcm_drp_reconfig

Overview:
- Sequences runtime reconfiguration of one MMCME2_ADV through its DRP port.
- On a start pulse it holds the MMCM in reset. It then walks a register table and performs a read-modify-write on each DRP register. Finally it releases reset and waits for LOCKED.
- Sits beside the MMCM in the clocking top level and is driven by a free-running input clock, never by an MMCM output.
- The table is an external synchronous ROM, so one controller serves any multiply/divide/phase set.

Parameters:
- TABLE_DEPTH, 23, number of table entries processed per reconfiguration (1..32).
- TBL_AW, 5, table address width; 2^TBL_AW >= TABLE_DEPTH.
- RST_SETTLE, 8, clk cycles between asserting mmcm_rst and the first DRP access (>=1).
- DRDY_TIMEOUT, 255, maximum cycles from DEN to DRDY before error.
- LOCK_TIMEOUT, 65535, maximum cycles from mmcm_rst release to synchronized LOCKED before error.

Ports:
- clk  in  1  controller clock, free-running, also drives DCLK of the MMCM.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done or error.
- done  out  1  one-cycle pulse when LOCKED is reacquired.
- error  out  1  sticky fault flag; cleared by the next accepted start or by rst.
- tbl_addr  out  TBL_AW  table ROM address.
- tbl_data  in  39  ROM output one cycle after tbl_addr: [38:32] DRP addr, [31:16] keep-mask, [15:0] new bits.
- drp_addr  out  7  to DADDR.
- drp_di  out  16  to DI.
- drp_do  in  16  from DO.
- drp_den  out  1  to DEN.
- drp_dwe  out  1  to DWE.
- drp_drdy  in  1  from DRDY.
- mmcm_rst  out  1  to MMCM RST.
- mmcm_locked  in  1  MMCM LOCKED, asynchronous to clk.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, rst.
- Reset values:
  - busy=0, done=0, error=0.
  - tbl_addr=0, drp_addr=0, drp_di=0, drp_den=0, drp_dwe=0.
  - mmcm_rst=0, so the MMCM runs its bitstream configuration.
  - Entry index=0, all counters 0, FSM=IDLE.
- mmcm_locked passes through a 2-flop synchronizer (lock_s); this adds 2 cycles of latency.
- IDLE:
  - start=1 -> RST_WAIT, with mmcm_rst=1, busy=1, error=0, index=0 on the next edge.
  - start while busy is ignored.
- RST_WAIT: counts RST_SETTLE cycles -> FETCH.
- FETCH:
  - Drives tbl_addr=index, waits 1 cycle for ROM data.
  - Registers addr, mask and data, then -> RD.
- RD:
  - Drives drp_den=1, drp_dwe=0, drp_addr=entry addr for exactly 1 cycle -> RD_WAIT.
- RD_WAIT:
  - On drp_drdy=1, latches drp_do and computes new = (drp_do & mask) | (data & ~mask) -> WR.
  - If DRDY_TIMEOUT cycles pass without DRDY -> ERR.
- WR:
  - Drives drp_den=1, drp_dwe=1, drp_di=new for exactly 1 cycle -> WR_WAIT.
- WR_WAIT:
  - On drp_drdy: if index==TABLE_DEPTH-1 -> RELEASE; otherwise index+1 -> FETCH.
  - Timeout is handled as in RD_WAIT.
- drp_den is never asserted while a DRDY is outstanding. drp_den and drp_dwe are never high outside RD/WR.
- RELEASE: mmcm_rst=0, lock timeout counter cleared -> LOCK_WAIT.
- LOCK_WAIT:
  - lock_s=1 -> DONE.
  - Counter reaching LOCK_TIMEOUT -> ERR.
  - A stale high lock_s is impossible, because mmcm_rst was held at least RST_SETTLE+4 cycles.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- ERR: error=1 (sticky), busy=0, mmcm_rst=0 -> IDLE.
- A DRDY arriving in any state other than RD_WAIT/WR_WAIT is ignored.
- rst mid-operation: immediate return to reset values. The MMCM is released with whatever partial configuration was written, so software must re-issue start.
- Timeout counters saturate and do not wrap.
- Index arithmetic uses TBL_AW bits; TABLE_DEPTH=1 is legal.
- Nominal latency per entry: 1 fetch + 1 RD + drdy latency + 1 WR + drdy latency.

Test Plan:
- Nominal, 2-entry table:
  - Entries {0x08, mask 0x1000, data 0x0145} and {0x09, mask 0xFC00, data 0x0080}.
  - DRP model returns 0xFFFF with drdy 3 cycles after den; start pulse.
  - Required: writes 0x1145 then 0xFC80; mmcm_rst high from the cycle after start until the last write completes; LOCKED raised 100 cycles after release -> done pulse exactly 1 cycle, 2 cycles after LOCKED rises.
- DRDY timeout:
  - The DRP model never returns drdy on entry 0.
  - Required: error=1 exactly DRDY_TIMEOUT cycles after the den pulse; busy=0; mmcm_rst=0; no write issued.
- Lock timeout:
  - LOCKED held 0 with LOCK_TIMEOUT=1000.
  - Required: error=1 at 1000 cycles after release; no done pulse. The next start clears error in the following cycle.
- Start ignored while busy:
  - Pulse start at cycles 3, 20 and 50 of an operation.
  - Required: exactly one read/write pair per table entry; exactly one done pulse.
- Reset mid-operation:
  - Assert rst during WR_WAIT of entry 1.
  - Required: same-cycle (asynchronous) return of mmcm_rst=0, drp_den=0, busy=0; after rst release, a full sequence restarts from index 0 on start.
- Masking corner:
  - mask 0xFFFF with data 0x1234 on drp_do 0xABCD -> writes 0xABCD.
  - mask 0x0000 -> writes 0x1234.
